// File: rtl/instr_pkg.sv
// Shared instruction-word layout and loader state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_pkg;

    localparam int INSTR_W     = 9;
    localparam int FORMAT_BIT  = 8;
    localparam int OPCODE_MSB  = 7;
    localparam int OPCODE_LSB  = 4;
    localparam int SIGN_BIT    = 3;
    localparam int OPERAND_MSB = 2;
    localparam int OPERAND_LSB = 0;
    localparam int IMM_MSB     = 7;
    localparam int IMM_LSB     = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/instr_encode.sv
// Packs decoded instruction fields into the 9-bit instruction word.
// Latency: purely combinational.
// Backpressure: none.
module instr_encode
    import instr_pkg::*;
(
    input  logic               format_i,
    input  logic [3:0]         opcode_i,
    input  logic               sign_i,
    input  logic [2:0]         operand_i,
    input  logic [7:0]         imm_i,
    output logic [INSTR_W-1:0] word_o
);

    always_comb begin
        word_o = '0;
        if (format_i) begin
            word_o[FORMAT_BIT]              = 1'b1;
            word_o[OPCODE_MSB:OPCODE_LSB]   = opcode_i;
            word_o[SIGN_BIT]                = sign_i;
            word_o[OPERAND_MSB:OPERAND_LSB] = operand_i;
        end else begin
            word_o[IMM_MSB:IMM_LSB] = imm_i;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Streams instruction fields into instruction RAM while holding the CPU; optional INSTR_LOADER_CHECKSUM_EN.
// Latency: 1 cycle from accepted field set to mem_we; done 2 cycles after the last transfer.
// Backpressure: in_ready is a pure state decode (high only in LOAD), one write per cycle.
module instr_loader
    import instr_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W-1:0]  length,
    input  logic               abort,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_format,
    input  logic [3:0]         in_opcode,
    input  logic               in_sign,
    input  logic [2:0]         in_operand,
    input  logic [7:0]         in_immediate,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               err
`ifdef INSTR_LOADER_CHECKSUM_EN
    ,
    output logic [15:0]        checksum
`endif
);

    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    loader_state_e      state_q, state_d;
    logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0]  remaining_q, remaining_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic               we_q, we_d;
    logic               err_q, err_d;
    logic               start_ok;
    logic [INSTR_W-1:0] packed_word;
    logic [ADDR_W:0]    end_addr;

    instr_encode u_encode (
        .format_i  (in_format),
        .opcode_i  (in_opcode),
        .sign_i    (in_sign),
        .operand_i (in_operand),
        .imm_i     (in_immediate),
        .word_o    (packed_word)
    );

    // Widened by one bit so base+length cannot wrap past the RAM end.
    assign end_addr = {1'b0, base_addr} + {1'b0, length};

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        err_d       = 1'b0;
        start_ok    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (end_addr > DEPTH_LIM) begin
                        err_d = 1'b1;
                    end else begin
                        start_ok = 1'b1;
                        if (length == '0) begin
                            state_d = DONE;
                        end else begin
                            cur_addr_d  = base_addr;
                            remaining_d = length;
                            state_d     = LOAD;
                        end
                    end
                end
            end
            LOAD: begin
                // Abort wins over a coincident transfer; that word is dropped.
                if (abort) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    we_d        = 1'b1;
                    addr_d      = cur_addr_q;
                    wdata_d     = packed_word;
                    cur_addr_d  = cur_addr_q + ONE;
                    remaining_d = remaining_q - ONE;
                    if (remaining_q == ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign cpu_hold  = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [15:0] checksum_q;

    // Accumulates on the memory-port strobe so only words actually written count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if (start_ok) begin
            checksum_q <= '0;
        end else if (we_q) begin
            checksum_q <= checksum_q + 16'(wdata_q);
        end
    end

    assign checksum = checksum_q;
`endif

endmodule
